mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency instruction/data memory between the pipeline's fetch port (IF) and data-access port (MEM, lw/sw).
- Each requester uses a req/done handshake.
- The arbiter serialises accesses, sequences the memory for MEM_LAT cycles, returns read data in a registered buffer, and pulses done.
- The pipeline controller uses done to release stalls.

Parameters:
ADDR_W, 32, address width of both ports and memory
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles, integer >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch address, stable while if_req
if_rdata  out  DATA_W  fetched word, registered
if_done  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request, held until d_done
d_we  in  1  1=store (sw), 0=load (lw)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  loaded word, registered
d_done  out  1  one-cycle completion pulse for data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid in last ACCESS cycle

Behaviour:
- Reset (asynchronous, rst, active-high):
  - State = IDLE; all outputs 0; counter 0.
  - last_grant = IF, so D wins the first tie.
  - Reset mid-access aborts the access; no done pulse is issued.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If no req: stay in IDLE; mem_en = 0.
  - If exactly one req: grant that port.
  - If both req: grant the port opposite last_grant (round robin).
  - On grant: latch addr, we (0 for IF), wdata (0 for IF), and granted port into internal registers; update last_grant; cnt <= 0; go to ACCESS.
- ACCESS:
  - mem_en = 1, mem_addr/mem_we/mem_wdata driven from latched registers every cycle. Memory outputs depend only on registered state.
  - cnt increments each cycle.
  - When cnt == MEM_LAT-1:
    - On a read, capture mem_rdata into if_rdata or d_rdata of the granted port.
    - Go to RESP.
- RESP:
  - mem_en = 0; assert the granted port's done for exactly one cycle.
  - Next state is always IDLE. No arbitration occurs in RESP.
- Stores: d_rdata unchanged; d_done still pulses.
- Handshake:
  - Requester keeps req, addr, we, and wdata stable until it sees done.
  - Requester deasserts req on the same clock edge at which done is high.
  - A req still high in the following IDLE cycle is a new request.
- Latency: req first seen in IDLE at cycle t → ACCESS t+1 .. t+MEM_LAT → done at cycle t+MEM_LAT+1.
  - Throughput: one access per MEM_LAT+2 cycles.
- The non-granted port waits with req held; it is guaranteed service at the next IDLE. Starvation is impossible.
- rdata registers hold their value until overwritten by that port's next read.
- Address or data changes while req is held are ignored after latching.
- The counter is wide enough for MEM_LAT; no wrap within one access.

Optional Feature:
- Macro: ARB_CONFLICT_CNT_EN.
- Defined:
  - Adds output conflict_cnt [15:0], reset to 0.
  - Increments on every IDLE cycle where if_req and d_req are both 1.
  - Saturates at 16'hFFFF.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Single load, MEM_LAT=2:
  - Stimulus: d_req=1, d_we=0, d_addr=0x40 at cycle 0; memory returns 0xDEADBEEF.
  - Response: mem_en high cycles 1–2 with mem_addr=0x40, mem_we=0; d_done pulse at cycle 3; d_rdata=0xDEADBEEF; if_done never pulses.
- Single store:
  - Stimulus: d_we=1, d_addr=0x80, d_wdata=0x12345678.
  - Response: mem_we=1 and mem_wdata=0x12345678 for 2 cycles; d_done at cycle 3; d_rdata unchanged.
- Simultaneous requests after reset:
  - Stimulus: if_req (0x0) and d_req (0x100) at cycle 0.
  - Response: D served first, d_done at cycle 3; IF granted in IDLE at cycle 4, if_done at cycle 7.
- Back-to-back fetches with d_req held continuously:
  - Response: grants alternate IF, D, IF.
  - With ARB_CONFLICT_CNT_EN: conflict_cnt increments once per contested IDLE cycle.
- Reset mid-access:
  - Stimulus: rst asserted during the first ACCESS cycle.
  - Response: mem_en=0 immediately; no done pulse; state IDLE; a re-issued req completes normally.
- MEM_LAT=1:
  - Stimulus: single fetch at cycle 0.
  - Response: one mem_en cycle; if_done at cycle 2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, fixed-latency memory between the fetch port (IF)
// and the data-access port (D, lw/sw). Requests are serialised through an
// IDLE -> ACCESS -> RESP sequence. Simultaneous requests are resolved round
// robin against the last granted port, so neither port can starve. Read data
// is returned in a per-port holding register together with a one-cycle done
// pulse.
//
// Parameters
//   ADDR_W   address width of both ports and of the memory
//   DATA_W   data width
//   MEM_LAT  memory access cycles (>= 1)
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   if_req/if_addr            fetch request, held until if_done
//   if_rdata/if_done          fetched word (registered), completion pulse
//   d_req/d_we/d_addr/d_wdata data request (d_we=1 store), held until d_done
//   d_rdata/d_done            loaded word (registered), completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_rdata                 memory read data, valid in last ACCESS cycle
//   conflict_cnt              saturating count of contested IDLE cycles;
//                             present only when ARB_CONFLICT_CNT_EN is defined
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
`ifdef ARB_CONFLICT_CNT_EN
   output logic [15:0]       conflict_cnt,
`endif
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Counter holds 0..MEM_LAT so the increment in the last cycle never wraps.
   localparam int               CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             gnt_d_r;       // port owning the access in flight (1 = D)
   logic             last_gnt_d_r;  // port granted most recently (1 = D)
   logic             pick_d_s;

   // Round robin: D wins when it asks alone, or when both ask and IF went last.
   always_comb begin
      pick_d_s = 1'b0;
      if (d_req && (!if_req || !last_gnt_d_r)) begin
         pick_d_s = 1'b1;
      end else begin
         pick_d_s = 1'b0;
      end
   end

   // Arbitration, memory sequencing and registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         gnt_d_r      <= 1'b0;
         last_gnt_d_r <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= {ADDR_W{1'b0}};
         mem_wdata    <= {DATA_W{1'b0}};
         if_rdata     <= {DATA_W{1'b0}};
         d_rdata      <= {DATA_W{1'b0}};
         if_done      <= 1'b0;
         d_done       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if_done <= 1'b0;
               d_done  <= 1'b0;
               if (if_req || d_req) begin
                  // Latch the winner's command; the memory sees only these
                  // registers, so requester changes after this edge are ignored.
                  gnt_d_r      <= pick_d_s;
                  last_gnt_d_r <= pick_d_s;
                  mem_we       <= pick_d_s & d_we;
                  mem_addr     <= pick_d_s ? d_addr : if_addr;
                  mem_wdata    <= pick_d_s ? d_wdata : {DATA_W{1'b0}};
                  mem_en       <= 1'b1;
                  cnt_r        <= {CNT_W{1'b0}};
                  state_r      <= ST_ACCESS;
               end else begin
                  mem_en  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            ST_ACCESS: begin
               cnt_r <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  mem_en  <= 1'b0;
                  mem_we  <= 1'b0;
                  state_r <= ST_RESP;
                  // mem_we still carries the latched direction in this cycle.
                  if (!mem_we && !gnt_d_r) begin
                     if_rdata <= mem_rdata;
                  end else if (!mem_we && gnt_d_r) begin
                     d_rdata <= mem_rdata;
                  end else begin
                     d_rdata <= d_rdata;
                  end
                  if_done <= !gnt_d_r;
                  d_done  <= gnt_d_r;
               end else begin
                  state_r <= ST_ACCESS;
               end
            end
            ST_RESP: begin
               if_done <= 1'b0;
               d_done  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               mem_en  <= 1'b0;
               mem_we  <= 1'b0;
               if_done <= 1'b0;
               d_done  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ARB_CONFLICT_CNT_EN
   // Saturating count of IDLE cycles in which both ports were requesting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= 16'h0000;
      end else if ((state_r == ST_IDLE) && if_req && d_req && (conflict_cnt != 16'hFFFF)) begin
         conflict_cnt <= conflict_cnt + 16'h0001;
      end else begin
         conflict_cnt <= conflict_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench. A reference model decides, per arbitration opportunity,
// which port is served and what it must receive, and queues that expectation;
// a negedge monitor checks the memory command, the done pulses, their cycle
// and the returned data against the queue head. A second instance with
// MEM_LAT=1 covers the single-cycle access case.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ML = 2;

   logic        clk, rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata;
   logic        if_done, d_done;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt, l1_conflict_cnt;
`endif

   // MEM_LAT = 1 instance signals
   logic        l1_if_req, l1_if_done, l1_d_done, l1_mem_en, l1_mem_we;
   logic [31:0] l1_if_addr, l1_if_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(ML)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
`ifdef ARB_CONFLICT_CNT_EN
      .conflict_cnt(conflict_cnt),
`endif
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_done(l1_if_done),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0000_0000), .d_wdata(32'h0000_0000),
      .d_rdata(l1_d_rdata), .d_done(l1_d_done),
`ifdef ARB_CONFLICT_CNT_EN
      .conflict_cnt(l1_conflict_cnt),
`endif
      .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
      .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // ---------------- memory device behind the DUT ----------------
   logic [31:0] tb_mem  [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   function automatic logic [31:0] dev_rd(input logic [31:0] a);
      return tb_mem.exists(a) ? tb_mem[a] : hash(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : hash(a);
   endfunction

   always @(negedge clk) mem_rdata = (mem_en && !mem_we) ? dev_rd(mem_addr) : 32'h0BAD_0BAD;
   always @(posedge clk) if (!rst && mem_en && mem_we) tb_mem[mem_addr] = mem_wdata;
   assign l1_mem_rdata = hash(l1_mem_addr);

   // ---------------- reference model ----------------
   typedef struct {
      bit          port;      // 1 = D
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;     // value the port's rdata register must show at done
      int          done_cyc;
   } exp_t;

   exp_t        exp_q[$];
   bit          done_log[$];
   exp_t        m_e;
   int          cyc = 0;
   int          busy = 0;     // cycles until the arbiter can decide again
   bit          last_d = 1'b0;
   logic [31:0] d_hold = 32'h0;
   logic [15:0] conf_m = 16'h0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         busy   = 0;
         last_d = 1'b0;
         d_hold = 32'h0;
         conf_m = 16'h0;
      end else begin
         if (busy > 0) begin
            busy = busy - 1;
         end else begin
            if (if_req && d_req && conf_m != 16'hFFFF) conf_m = conf_m + 16'h1;
            if (if_req || d_req) begin
               if (if_req && d_req) m_e.port = !last_d;   // alternate on a tie
               else                 m_e.port = d_req;     // lone requester
               last_d = m_e.port;
               if (m_e.port) begin
                  m_e.addr  = d_addr;
                  m_e.we    = d_we;
                  m_e.wdata = d_wdata;
                  if (d_we) ref_mem[d_addr] = d_wdata;
                  else      d_hold = ref_rd(d_addr);
                  m_e.rdata = d_hold;
               end else begin
                  m_e.addr  = if_addr;
                  m_e.we    = 1'b0;
                  m_e.wdata = 32'h0;
                  m_e.rdata = ref_rd(if_addr);
               end
               m_e.done_cyc = cyc + ML + 1;
               busy = ML + 1;
               exp_q.push_back(m_e);
            end
         end
         cyc = cyc + 1;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      bit   exp_en;
      exp_t h;
      if (rst) begin
         chk("rst_mem_en",   32'(mem_en),   32'h0);
         chk("rst_mem_we",   32'(mem_we),   32'h0);
         chk("rst_mem_addr", mem_addr,      32'h0);
         chk("rst_done",     32'({if_done, d_done}), 32'h0);
         chk("rst_if_rdata", if_rdata,      32'h0);
         chk("rst_d_rdata",  d_rdata,       32'h0);
`ifdef ARB_CONFLICT_CNT_EN
         chk("rst_conflict", 32'(conflict_cnt), 32'h0);
`endif
      end else begin
         exp_en = 1'b0;
         if (exp_q.size() > 0) begin
            h = exp_q[0];
            exp_en = (cyc >= h.done_cyc - ML) && (cyc < h.done_cyc);
         end
         chk("mem_en", 32'(mem_en), 32'(exp_en));
         if (mem_en && exp_en) begin
            chk("mem_addr",  mem_addr,       h.addr);
            chk("mem_we",    32'(mem_we),    32'(h.we));
            chk("mem_wdata", mem_wdata,      h.wdata);
         end
         if (if_done || d_done) begin
            if (exp_q.size() == 0) begin
               chk("spurious_done", 32'({if_done, d_done}), 32'h0);
            end else begin
               chk("done_port",  32'({if_done, d_done}), h.port ? 32'h1 : 32'h2);
               chk("done_cycle", 32'(cyc), 32'(h.done_cyc));
               chk(h.port ? "d_rdata" : "if_rdata", h.port ? d_rdata : if_rdata, h.rdata);
               done_log.push_back(d_done);
               void'(exp_q.pop_front());
            end
         end else if (exp_q.size() > 0 && cyc >= h.done_cyc) begin
            chk("missing_done", 32'h0, 32'h1);
            void'(exp_q.pop_front());
         end
`ifdef ARB_CONFLICT_CNT_EN
         chk("conflict_cnt", 32'(conflict_cnt), 32'(conf_m));
`endif
      end
   end

   // ---------------- requester agents ----------------
   task automatic txn(input bit p, input logic [31:0] a, input logic we, input logic [31:0] wd,
                      output int s, output int dc);
      if (p) begin d_addr = a; d_we = we; d_wdata = wd; d_req = 1'b1; end
      else   begin if_addr = a; if_req = 1'b1; end
      s  = cyc;
      dc = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (p ? d_done : if_done) begin dc = cyc; break; end
      end
      if (dc < 0) chk(p ? "d_done_timeout" : "if_done_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      if (p) d_req = 1'b0; else if_req = 1'b0;
   endtask

   task automatic run(input bit p, input int n, input int maxgap);
      int s, dc, g;
      logic [31:0] a, wd;
      logic we;
      for (int i = 0; i < n; i++) begin
         a  = p ? 32'h2000 + 32'(4 * $urandom_range(0, 7)) : 32'h1000 + 32'(4 * $urandom_range(0, 63));
         we = p ? 1'($urandom_range(0, 1)) : 1'b0;
         wd = $urandom;
         txn(p, a, we, wd, s, dc);
         g = $urandom_range(0, maxgap);
         repeat (g) begin @(posedge clk); #1; end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; l1_if_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int s, dc, s2, dc2, en_n;
      logic [15:0] c0;
      if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_we = 1'b0;
      l1_if_addr = 32'h0;
      do_reset();

      // single load: memory word 0x40 holds 0xDEADBEEF
      tb_mem[32'h40]  = 32'hDEAD_BEEF;
      ref_mem[32'h40] = 32'hDEAD_BEEF;
      txn(1'b1, 32'h40, 1'b0, 32'h0, s, dc);
      chk("load_done_cycle", 32'(dc), 32'(s + ML + 1));
      chk("load_rdata", d_rdata, 32'hDEAD_BEEF);

      // single store: d_rdata must keep the loaded word
      txn(1'b1, 32'h80, 1'b1, 32'h1234_5678, s, dc);
      chk("store_done_cycle", 32'(dc), 32'(s + ML + 1));
      chk("store_keeps_rdata", d_rdata, 32'hDEAD_BEEF);
      chk("store_mem_word", dev_rd(32'h80), 32'h1234_5678);

      // simultaneous requests right after reset: D first, then IF
      do_reset();
      fork
         txn(1'b0, 32'h0,   1'b0, 32'h0, s,  dc);
         txn(1'b1, 32'h100, 1'b0, 32'h0, s2, dc2);
      join
      chk("tie_d_done_cycle",  32'(dc2), 32'(s2 + ML + 1));
      chk("tie_if_done_cycle", 32'(dc),  32'(s + 2 * ML + 3));

      // back-to-back fetches with D held: IF, D, IF, D, IF, D
      repeat (2) @(posedge clk); #1;
      done_log.delete();
`ifdef ARB_CONFLICT_CNT_EN
      c0 = conflict_cnt;
`else
      c0 = 16'h0;
`endif
      fork
         run(1'b0, 3, 0);
         begin @(posedge clk); #1; run(1'b1, 3, 0); end
      join
      chk("alt_count", 32'(done_log.size()), 32'd6);
      foreach (done_log[i]) chk("alt_order", 32'(done_log[i]), 32'(i % 2));
`ifdef ARB_CONFLICT_CNT_EN
      chk("alt_conflicts", 32'(conflict_cnt - c0), 32'd4);
`else
      chk("alt_conflicts_absent", 32'(c0), 32'h0);
`endif

      // reset during the first ACCESS cycle aborts the load
      repeat (2) @(posedge clk); #1;
      d_addr = 32'h2010; d_we = 1'b0; d_req = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; d_req = 1'b0;
      #1;
      chk("abort_mem_en", 32'(mem_en), 32'h0);
      chk("abort_d_done", 32'(d_done), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) @(posedge clk); #1;
      txn(1'b1, 32'h2010, 1'b0, 32'h0, s, dc);
      chk("reissue_done_cycle", 32'(dc), 32'(s + ML + 1));

      // randomized traffic on both ports
      fork
         run(1'b0, 40, 3);
         run(1'b1, 40, 3);
      join
      repeat (ML + 3) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      // MEM_LAT = 1: one access cycle, done two cycles after the request
      @(posedge clk); #1;
      l1_if_addr = 32'h3000; l1_if_req = 1'b1;
      s = cyc; dc = -1; en_n = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (l1_mem_en) en_n++;
         chk("l1_d_done", 32'(l1_d_done), 32'h0);
         if (l1_if_done) begin
            dc = cyc;
            @(posedge clk); #1 l1_if_req = 1'b0;
         end
      end
      chk("l1_mem_en_cycles", 32'(en_n), 32'd1);
      chk("l1_done_cycle",    32'(dc),   32'(s + 2));
      chk("l1_if_rdata",      l1_if_rdata, hash(32'h3000));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
